xbar_slave_arbiter: RTL

// Per-slave arbiter for the 4-master / 4-slave crossbar. One instance sits in front of each slave port.
// It selects among masters whose address targets this slave (addr[31:30] == SLAVE_ID) using round-robin.
// It forwards the winner's single read/write transaction to the slave and returns ack/rdata to that master only.
// It guards the slave handshake with a timeout so a dead slave cannot hang the crossbar.

---
 rtl/xbar_slave_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/xbar_slave_arbiter.sv
// Per-slave arbiter for a 4x4 crossbar: round-robin among masters addressing
// this slave, single outstanding transaction, and a timeout on the slave ack.
module xbar_slave_arbiter #(
   parameter int         N_MASTERS = 4,
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter logic [1:0] SLAVE_ID  = 2'b00,
   parameter int         TIMEOUT   = 16
) (
   input  logic                        iClk,
   input  logic                        iRst,
   input  logic [N_MASTERS-1:0]        iReq,
   input  logic [N_MASTERS*ADDR_W-1:0] iAddr,
   input  logic [N_MASTERS*DATA_W-1:0] iWdata,
   input  logic [N_MASTERS-1:0]        iOper,
   output logic [N_MASTERS-1:0]        oAck,
   output logic                        oErr,
   output logic [DATA_W-1:0]           oRdata,
   output logic [N_MASTERS-1:0]        oGrant,
   output logic                        oSlv_req,
   output logic [ADDR_W-1:0]           oSlv_addr,
   output logic [DATA_W-1:0]           oSlv_wdata,
   output logic                        oSlv_oper,
   input  logic                        iSlv_ack,
   input  logic [DATA_W-1:0]           iSlv_rdata
);

   localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [N_MASTERS-1:0]   ack_q, ack_d;
   logic                   err_q, err_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [N_MASTERS-1:0]   grant_q, grant_d;
   logic                   slv_req_q, slv_req_d;
   logic [ADDR_W-1:0]      slv_addr_q, slv_addr_d;
   logic [DATA_W-1:0]      slv_wdata_q, slv_wdata_d;
   logic                   slv_oper_q, slv_oper_d;

   logic [N_MASTERS-1:0]   elig;
   logic                   any_elig;
   logic [IDX_W-1:0]       win;
   logic [IDX_W-1:0]       idx;

   // A master is eligible only when its address top bits select this slave
   for (genvar i = 0; i < N_MASTERS; i++) begin : g_elig
      assign elig[i] = iReq[i] & (iAddr[i*ADDR_W + ADDR_W-1 -: 2] == SLAVE_ID);
   end

   // Round-robin pick: first eligible index starting at ptr, wrapping
   always_comb begin
      any_elig = 1'b0;
      win      = '0;
      idx      = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         idx = IDX_W'((int'(ptr_q) + k) % N_MASTERS);
         if (!any_elig && elig[idx]) begin
            any_elig = 1'b1;
            win      = idx;
         end
      end
   end

   // FSM next state and registered-output next values
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      ack_d       = '0;
      err_d       = 1'b0;
      rdata_d     = '0;
      grant_d     = grant_q;
      slv_req_d   = slv_req_q;
      slv_addr_d  = slv_addr_q;
      slv_wdata_d = slv_wdata_q;
      slv_oper_d  = slv_oper_q;
      case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               owner_d     = win;
               grant_d     = N_MASTERS'(1) << win;
               slv_addr_d  = iAddr[int'(win)*ADDR_W +: ADDR_W];
               slv_wdata_d = iWdata[int'(win)*DATA_W +: DATA_W];
               slv_oper_d  = iOper[win];
               slv_req_d   = 1'b1;
               cnt_d       = '0;
               state_d     = S_BUS;
            end
         end
         S_BUS: begin
            // an ack arriving on the last allowed cycle still counts as success
            if (iSlv_ack) begin
               rdata_d   = slv_oper_q ? '0 : iSlv_rdata;
               ack_d     = grant_q;
               slv_req_d = 1'b0;
               state_d   = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               err_d     = 1'b1;
               ack_d     = grant_q;
               slv_req_d = 1'b0;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            // the served master drops to lowest priority for the next round
            ptr_d   = IDX_W'((int'(owner_q) + 1) % N_MASTERS);
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         grant_q     <= '0;
         slv_req_q   <= 1'b0;
         slv_addr_q  <= '0;
         slv_wdata_q <= '0;
         slv_oper_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         grant_q     <= grant_d;
         slv_req_q   <= slv_req_d;
         slv_addr_q  <= slv_addr_d;
         slv_wdata_q <= slv_wdata_d;
         slv_oper_q  <= slv_oper_d;
      end
   end

   assign oAck       = ack_q;
   assign oErr       = err_q;
   assign oRdata     = rdata_q;
   assign oGrant     = grant_q;
   assign oSlv_req   = slv_req_q;
   assign oSlv_addr  = slv_addr_q;
   assign oSlv_wdata = slv_wdata_q;
   assign oSlv_oper  = slv_oper_q;

endmodule
